// File: rtl/branch_target_resolve.sv
// Branch target buffer with EX-stage resolution.
// Fetch side: direct-mapped lookup of pc_i, combined with the 2-bit counter
// taken bit to produce the next fetch PC. EX side: resolves a conditional
// branch, strobes the counter table, fills the BTB on taken branches, and
// raises a one-cycle flush with restart PC on a mispredict. Keeps saturating
// branch/mispredict statistics.
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   pc_i, bht_taken_i            fetch lookup PC and counter-table taken bit
//   pred_taken_o, pred_pc_o      fetch prediction (combinational)
//   ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i,
//   ex_pred_taken_i, ex_pred_pc_i    resolving branch and its carried prediction
//   increment_counter_o, decrement_counter_o   counter-table strobes (combinational)
//   flush_o, redirect_pc_o       registered flush pulse and restart PC
//   branch_count_o, mispredict_count_o         saturating statistics
module branch_target_resolve #(
  parameter int unsigned N = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic        bht_taken_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_pc_o,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_pc_i,
  output logic        increment_counter_o,
  output logic        decrement_counter_o,
  output logic        flush_o,
  output logic [31:0] redirect_pc_o,
  output logic [15:0] branch_count_o,
  output logic [15:0] mispredict_count_o
);

  localparam int unsigned IDX_W   = N - 1;
  localparam int unsigned ENTRIES = 2 ** IDX_W;
  localparam int unsigned TAG_W   = 31 - N;
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic               flush_q, flush_d;
  logic [31:0]        redirect_q, redirect_d;
  logic [CNT_W-1:0]   branch_count_q, branch_count_d;
  logic [CNT_W-1:0]   mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0]   rd_idx, wr_idx;
  logic [TAG_W-1:0]   rd_tag, wr_tag;
  logic               hit;
  logic               effective;
  logic               mispredict;
  logic               tbl_we;

  // Fetch lookup; reads the table before any same-cycle write lands
  always_comb begin
    rd_idx       = pc_i[N:2];
    rd_tag       = pc_i[31:N+1];
    hit          = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    pred_taken_o = hit && bht_taken_i;
    pred_pc_o    = pred_taken_o ? target_q[rd_idx] : pc_i + 32'd4;
  end

  // EX resolution; branches seen while flushing are wrong-path and ignored
  always_comb begin
    effective           = ex_valid_i && (state_q == ST_RUN);
    increment_counter_o = effective && ex_taken_i;
    decrement_counter_o = effective && !ex_taken_i;
    mispredict          = effective &&
                          ((ex_pred_taken_i != ex_taken_i) ||
                           (ex_taken_i && (ex_pred_pc_i != ex_target_i)));
    tbl_we              = effective && ex_taken_i;
    wr_idx              = ex_pc_i[N:2];
    wr_tag              = ex_pc_i[31:N+1];
  end

  // Next-state, flush/redirect, valid bits and statistics
  always_comb begin
    state_d            = state_q;
    flush_d            = 1'b0;
    redirect_d         = redirect_q;
    valid_d            = valid_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;

    case (state_q)
      ST_RUN: begin
        if (mispredict) begin
          state_d    = ST_FLUSH;
          flush_d    = 1'b1;
          redirect_d = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    if (tbl_we) begin
      valid_d[wr_idx] = 1'b1;
    end
    if (effective && (branch_count_q != CNT_MAX)) begin
      branch_count_d = branch_count_q + CNT_W'(1);
    end
    if (mispredict && (mispredict_count_q != CNT_MAX)) begin
      mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end
  end

  // Control and statistics registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q            <= ST_RUN;
      valid_q            <= '0;
      flush_q            <= 1'b0;
      redirect_q         <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      state_q            <= state_d;
      valid_q            <= valid_d;
      flush_q            <= flush_d;
      redirect_q         <= redirect_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // Tag/target storage is qualified by valid, so it needs no reset
  always_ff @(posedge clk_i) begin
    if (tbl_we) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= ex_target_i;
    end
  end

  assign flush_o            = flush_q;
  assign redirect_pc_o      = redirect_q;
  assign branch_count_o     = branch_count_q;
  assign mispredict_count_o = mispredict_count_q;

endmodule

// File: tb/tb_branch_target_resolve.sv
// Self-checking bench for branch_target_resolve: a small BTB/FSM model
// predicts lookups, strobes and statistics; expected restart PCs are queued
// when a mispredict is driven and popped when flush_o appears.
module tb_branch_target_resolve;

  localparam int unsigned N       = 10;
  localparam int unsigned IDX_W   = N - 1;
  localparam int unsigned ENTRIES = 2 ** IDX_W;
  localparam int unsigned TAG_W   = 31 - N;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        bht_taken_i;
  logic        pred_taken_o;
  logic [31:0] pred_pc_o;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_pc_i;
  logic        increment_counter_o;
  logic        decrement_counter_o;
  logic        flush_o;
  logic [31:0] redirect_pc_o;
  logic [15:0] branch_count_o;
  logic [15:0] mispredict_count_o;

  branch_target_resolve #(.N(N)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .pc_i                (pc_i),
    .bht_taken_i         (bht_taken_i),
    .pred_taken_o        (pred_taken_o),
    .pred_pc_o           (pred_pc_o),
    .ex_valid_i          (ex_valid_i),
    .ex_pc_i             (ex_pc_i),
    .ex_taken_i          (ex_taken_i),
    .ex_target_i         (ex_target_i),
    .ex_pred_taken_i     (ex_pred_taken_i),
    .ex_pred_pc_i        (ex_pred_pc_i),
    .increment_counter_o (increment_counter_o),
    .decrement_counter_o (decrement_counter_o),
    .flush_o             (flush_o),
    .redirect_pc_o       (redirect_pc_o),
    .branch_count_o      (branch_count_o),
    .mispredict_count_o  (mispredict_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  logic             m_valid [ENTRIES];
  logic [TAG_W-1:0] m_tag   [ENTRIES];
  logic [31:0]      m_tgt   [ENTRIES];
  logic             m_flush;
  logic [15:0]      m_bc, m_mc;
  logic [31:0]      exp_redir_q [$];

  task automatic model_reset();
    for (int i = 0; i < int'(ENTRIES); i++) m_valid[i] = 1'b0;
    m_flush = 1'b0;
    m_bc    = '0;
    m_mc    = '0;
    exp_redir_q.delete();
  endtask

  function automatic logic [32:0] model_pred(input logic [31:0] pc, input logic bht);
    logic [IDX_W-1:0] i;
    i = pc[N:2];
    if (bht && m_valid[i] && (m_tag[i] == pc[31:N+1])) return {1'b1, m_tgt[i]};
    return {1'b0, pc + 32'd4};
  endfunction

  task automatic drive_ex(input logic v, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ppc);
    ex_valid_i      = v;
    ex_pc_i         = pc;
    ex_taken_i      = tk;
    ex_target_i     = tgt;
    ex_pred_taken_i = ptk;
    ex_pred_pc_i    = ppc;
  endtask

  // Advance one clock, updating the model from the inputs driven this cycle
  task automatic tick();
    logic eff, misp;
    logic [IDX_W-1:0] wi;
    eff  = ex_valid_i && !m_flush;
    misp = eff && ((ex_pred_taken_i != ex_taken_i) ||
                   (ex_taken_i && (ex_pred_pc_i != ex_target_i)));
    wi   = ex_pc_i[N:2];
    if (misp) exp_redir_q.push_back(ex_taken_i ? ex_target_i : ex_pc_i + 32'd4);
    @(posedge clk_i);
    if (eff && ex_taken_i) begin
      m_valid[wi] = 1'b1;
      m_tag[wi]   = ex_pc_i[31:N+1];
      m_tgt[wi]   = ex_target_i;
    end
    if (eff && (m_bc != 16'hFFFF)) m_bc = m_bc + 16'd1;
    if (misp && (m_mc != 16'hFFFF)) m_mc = m_mc + 16'd1;
    m_flush = misp;
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (flush_o !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b, expected 0", flush_o); end
    n_vec++; if (redirect_pc_o !== 32'h0) begin n_err++; $display("FAIL reset_redirect: got %h, expected 0", redirect_pc_o); end
    n_vec++; if ({branch_count_o, mispredict_count_o} !== 32'h0) begin n_err++; $display("FAIL reset_counts: got %h/%h, expected 0/0", branch_count_o, mispredict_count_o); end
  endtask

  task automatic test_cold_lookup();
    @(negedge clk_i);
    pc_i = 32'h100; bht_taken_i = 1'b1;
    #1;
    n_vec++; if ({pred_taken_o, pred_pc_o} !== {1'b0, 32'h104}) begin n_err++; $display("FAIL cold_lookup: got %b/%h, expected 0/00000104", pred_taken_o, pred_pc_o); end
    tick();
  endtask

  task automatic test_fill_hit();
    logic [32:0] e;
    @(negedge clk_i);
    pc_i = 32'h100; bht_taken_i = 1'b1;
    drive_ex(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    #1;
    n_vec++; if ({increment_counter_o, decrement_counter_o} !== 2'b10) begin n_err++; $display("FAIL fill_strobes: got %b%b, expected 10", increment_counter_o, decrement_counter_o); end
    n_vec++; if (pred_taken_o !== 1'b0) begin n_err++; $display("FAIL fill_prewrite: got %b, expected 0", pred_taken_o); end
    tick();
    @(negedge clk_i);
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    e = model_pred(pc_i, bht_taken_i);
    #1;
    n_vec++; if ({pred_taken_o, pred_pc_o} !== {1'b1, 32'h200} || {pred_taken_o, pred_pc_o} !== e) begin n_err++; $display("FAIL fill_hit: got %b/%h, expected 1/00000200", pred_taken_o, pred_pc_o); end
    n_vec++; if (branch_count_o !== m_bc) begin n_err++; $display("FAIL fill_bcount: got %h, expected %h", branch_count_o, m_bc); end
    bht_taken_i = 1'b0;
    #1;
    n_vec++; if ({pred_taken_o, pred_pc_o} !== {1'b0, 32'h104}) begin n_err++; $display("FAIL hit_bht0: got %b/%h, expected 0/00000104", pred_taken_o, pred_pc_o); end
    tick();
  endtask

  task automatic test_alias();
    @(negedge clk_i);
    pc_i = 32'h100 + (32'd1 << (N + 1)); bht_taken_i = 1'b1;
    #1;
    n_vec++; if ({pred_taken_o, pred_pc_o} !== {1'b0, pc_i + 32'd4}) begin n_err++; $display("FAIL tag_alias: got %b/%h, expected 0/%h", pred_taken_o, pred_pc_o, pc_i + 32'd4); end
    tick();
  endtask

  task automatic test_dir_mispredict();
    logic [31:0] r;
    @(negedge clk_i);
    drive_ex(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
    #1;
    n_vec++; if ({increment_counter_o, decrement_counter_o} !== 2'b01) begin n_err++; $display("FAIL dir_strobes: got %b%b, expected 01", increment_counter_o, decrement_counter_o); end
    tick();
    n_vec++; if (flush_o !== 1'b1) begin n_err++; $display("FAIL dir_flush: got %b, expected 1", flush_o); end
    r = (exp_redir_q.size() != 0) ? exp_redir_q.pop_front() : 32'hDEAD_BEEF;
    n_vec++; if (redirect_pc_o !== r || r !== 32'h44) begin n_err++; $display("FAIL dir_redirect: got %h, expected %h", redirect_pc_o, r); end
    n_vec++; if (mispredict_count_o !== 16'd1) begin n_err++; $display("FAIL dir_mcount: got %h, expected 0001", mispredict_count_o); end
    // Wrong-path branch in EX during the flush cycle
    @(negedge clk_i);
    drive_ex(1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 32'h304);
    #1;
    n_vec++; if ({increment_counter_o, decrement_counter_o} !== 2'b00) begin n_err++; $display("FAIL flush_strobes: got %b%b, expected 00", increment_counter_o, decrement_counter_o); end
    tick();
    @(negedge clk_i);
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    pc_i = 32'h300; bht_taken_i = 1'b1;
    #1;
    n_vec++; if ({flush_o, redirect_pc_o} !== {1'b0, 32'h44}) begin n_err++; $display("FAIL flush_end: got %b/%h, expected 0/00000044", flush_o, redirect_pc_o); end
    n_vec++; if ({branch_count_o, mispredict_count_o} !== {m_bc, m_mc}) begin n_err++; $display("FAIL flush_ignored_counts: got %h/%h, expected %h/%h", branch_count_o, mispredict_count_o, m_bc, m_mc); end
    n_vec++; if (pred_taken_o !== 1'b0) begin n_err++; $display("FAIL flush_no_write: got %b, expected 0", pred_taken_o); end
    tick();
  endtask

  task automatic test_target_mispredict();
    logic [31:0] r;
    @(negedge clk_i);
    drive_ex(1'b1, 32'h60, 1'b1, 32'h90, 1'b1, 32'h80);
    tick();
    r = (exp_redir_q.size() != 0) ? exp_redir_q.pop_front() : 32'hDEAD_BEEF;
    n_vec++; if ({flush_o, redirect_pc_o} !== {1'b1, r} || r !== 32'h90) begin n_err++; $display("FAIL tgt_flush: got %b/%h, expected 1/%h", flush_o, redirect_pc_o, r); end
    @(negedge clk_i);
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    pc_i = 32'h60; bht_taken_i = 1'b1;
    #1;
    n_vec++; if ({pred_taken_o, pred_pc_o} !== {1'b1, 32'h90}) begin n_err++; $display("FAIL tgt_entry: got %b/%h, expected 1/00000090", pred_taken_o, pred_pc_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] bpc, tgt;
    logic        tk;
    logic [32:0] e;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_i);
      bpc = {$urandom_range(0, 1023) << 2};
      bpc[31:12] = 20'($urandom_range(0, 3));
      tgt = {$urandom} & 32'hFFFF_FFFC;
      tk  = 1'($urandom_range(0, 1));
      drive_ex(1'b1, bpc, tk, tgt, tk, tk ? tgt : bpc + 32'd4);
      pc_i = (i % 3 == 0) ? bpc : {20'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)), 2'b00};
      bht_taken_i = 1'($urandom_range(0, 3) != 0);
      e = model_pred(pc_i, bht_taken_i);
      #1;
      n_vec++; if ({increment_counter_o, decrement_counter_o, pred_taken_o, pred_pc_o} !== {tk, !tk, e})
        begin n_err++; $display("FAIL b2b_%0d: got %b%b %b/%h, expected %b%b %b/%h", i, increment_counter_o, decrement_counter_o, pred_taken_o, pred_pc_o, tk, !tk, e[32], e[31:0]); end
      tick();
    end
    @(negedge clk_i);
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_vec++; if ({flush_o, branch_count_o, mispredict_count_o} !== {1'b0, m_bc, m_mc}) begin n_err++; $display("FAIL b2b_counts: got %b %h/%h, expected 0 %h/%h", flush_o, branch_count_o, mispredict_count_o, m_bc, m_mc); end
    tick();
  endtask

  task automatic test_saturation();
    logic [31:0] r;
    // Preload both counters just below saturation instead of 65536 real mispredicts
    @(negedge clk_i);
    force dut.branch_count_q     = 16'hFFFC;
    force dut.mispredict_count_q = 16'hFFFC;
    #1;
    release dut.branch_count_q;
    release dut.mispredict_count_q;
    m_bc = 16'hFFFC;
    m_mc = 16'hFFFC;
    for (int i = 0; i < 6; i++) begin
      drive_ex(1'b1, 32'h400 + 32'(i * 4), 1'b0, 32'h0, 1'b1, 32'h800);
      tick();
      r = (exp_redir_q.size() != 0) ? exp_redir_q.pop_front() : 32'hDEAD_BEEF;
      n_vec++; if ({flush_o, redirect_pc_o, mispredict_count_o} !== {1'b1, r, m_mc})
        begin n_err++; $display("FAIL sat_%0d: got %b/%h/%h, expected 1/%h/%h", i, flush_o, redirect_pc_o, mispredict_count_o, r, m_mc); end
      @(negedge clk_i);
      drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      @(negedge clk_i);
    end
    n_vec++; if ({branch_count_o, mispredict_count_o} !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_final: got %h/%h, expected ffff/ffff", branch_count_o, mispredict_count_o); end
  endtask

  task automatic test_reset_mid_flush();
    logic [31:0] r;
    @(negedge clk_i);
    drive_ex(1'b1, 32'h500, 1'b1, 32'h700, 1'b0, 32'h504);
    tick();
    r = (exp_redir_q.size() != 0) ? exp_redir_q.pop_front() : 32'hDEAD_BEEF;
    n_vec++; if ({flush_o, redirect_pc_o} !== {1'b1, r}) begin n_err++; $display("FAIL rst_pre_flush: got %b/%h, expected 1/%h", flush_o, redirect_pc_o, r); end
    // Assert reset between edges; outputs must clear without a clock
    rst_i = 1'b1;
    #1;
    model_reset();
    n_vec++; if ({flush_o, redirect_pc_o} !== 33'h0) begin n_err++; $display("FAIL rst_async_flush: got %b/%h, expected 0/0", flush_o, redirect_pc_o); end
    n_vec++; if ({branch_count_o, mispredict_count_o} !== 32'h0) begin n_err++; $display("FAIL rst_async_counts: got %h/%h, expected 0/0", branch_count_o, mispredict_count_o); end
    @(negedge clk_i);
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    pc_i = 32'h100; bht_taken_i = 1'b1;
    rst_i = 1'b0;
    #1;
    n_vec++; if (pred_taken_o !== 1'b0) begin n_err++; $display("FAIL rst_valid_clear: got %b, expected 0", pred_taken_o); end
    tick();
    n_vec++; if (flush_o !== 1'b0 || exp_redir_q.size() != 0) begin n_err++; $display("FAIL rst_drop_redirect: got %b, expected 0", flush_o); end
  endtask

  initial begin
    rst_i = 1'b1;
    pc_i = 32'h100;
    bht_taken_i = 1'b1;
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    model_reset();
    repeat (2) @(negedge clk_i);
    test_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    test_cold_lookup();
    test_fill_hit();
    test_alias();
    test_dir_mispredict();
    test_target_mispredict();
    test_back_to_back();
    test_saturation();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_target_resolve.md
BRANCH_TARGET_RESOLVE -- requirements
Module: branch_target_resolve

Interface
REQ-001 SHALL have parameter N, default 10, meaning that PC bits [N:2] index 2**(N-1) entries, matching the 2-bit counter table index.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port pc_i  input  32  fetch-stage PC; bits [1:0] are ignored.
REQ-005 SHALL have port bht_taken_i  input  1  taken bit from the 2-bit counter table for pc_i.
REQ-006 SHALL have port pred_taken_o  output  1  fetch prediction: redirect fetch to pred_pc_o.
REQ-007 SHALL have port pred_pc_o  output  32  predicted next fetch PC.
REQ-008 SHALL have port ex_valid_i  input  1  a conditional branch is resolving in EX this cycle.
REQ-009 SHALL have the following EX-stage input ports: ex_pc_i (32, branch PC), ex_taken_i (1, actual outcome), ex_target_i (32, actual target), ex_pred_taken_i (1, prediction carried down the pipe), ex_pred_pc_i (32, predicted PC carried down the pipe).
REQ-010 SHALL have ports increment_counter_o and decrement_counter_o  output  1 each  update strobes to the counter table, which is indexed by ex_pc_i.
REQ-011 SHALL have ports flush_o (output, 1, squash the younger stages) and redirect_pc_o (output, 32, fetch restart PC).
REQ-012 SHALL have ports branch_count_o and mispredict_count_o  output  16 each  statistics counters.

Function
REQ-013 SHALL hold 2**(N-1) entries, each with valid (1b), tag (pc[31:N+1]) and target (32b); idx = pc[N:2].
REQ-014 SHALL compute hit combinationally as valid[idx(pc_i)] && tag == pc_i[31:N+1].
REQ-015 SHALL drive pred_taken_o = hit && bht_taken_i, and pred_pc_o = target when pred_taken_o is 1, otherwise pc_i + 4 (mod 2**32).
REQ-016 SHALL treat ex_valid_i as effective only when ex_valid_i==1 and the FSM is in RUN.
REQ-017 SHALL drive increment_counter_o = effective && ex_taken_i and decrement_counter_o = effective && !ex_taken_i, combinationally in the same cycle; the two strobes are never both 1.
REQ-018 SHALL, on an effective taken branch, write valid=1, tag and target=ex_target_i at idx(ex_pc_i) on the rising edge, overwriting any previous entry; a not-taken branch leaves the entry unchanged.
REQ-019 SHALL give a lookup in the same cycle as a write to the same index the pre-write contents.
REQ-020 SHALL detect mispredict = effective && (ex_pred_taken_i != ex_taken_i || (ex_taken_i && ex_pred_pc_i != ex_target_i)).
REQ-021 SHALL implement FSM states RUN and FLUSH: RUN goes to FLUSH on mispredict; FLUSH goes to RUN unconditionally after one cycle.
REQ-022 SHALL register flush_o=1 only for the one cycle spent in FLUSH, with redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i + 4, captured at the mispredicting edge; redirect_pc_o holds its last value when flush_o=0.
REQ-023 SHALL treat ex_valid_i during FLUSH as a wrong-path branch: no table write, no counter strobes, no statistics update, no new mispredict.
REQ-024 SHALL increment branch_count_o by 1 per effective branch and mispredict_count_o by 1 per mispredict; both saturate at 16'hFFFF.

Reset
REQ-025 SHALL, while rst_i is high, clear all valid bits, set FSM=RUN, flush_o=0, redirect_pc_o=0, and both counters=0; tag and target contents are don't-care.
REQ-026 SHALL, when rst_i asserts mid-FLUSH, deassert flush_o immediately (asynchronously) and drop the pending redirect.
REQ-027 SHALL keep pred_taken_o=0 after reset until the first taken-branch write, regardless of bht_taken_i.

Verification
REQ-028 SHALL be verified with cold lookup: after reset, pc_i=0x100, bht_taken_i=1 -> pred_taken_o=0, pred_pc_o=0x104.
REQ-029 SHALL be verified with fill-and-hit: effective taken branch ex_pc_i=0x100, ex_target_i=0x200; next cycle pc_i=0x100, bht_taken_i=1 -> pred_taken_o=1, pred_pc_o=0x200, and increment_counter_o was 1 in the update cycle.
REQ-030 SHALL be verified with a tag alias: after the REQ-029 fill, pc_i=0x100+2**(N+1) -> pred_taken_o=0.
REQ-031 SHALL be verified with a direction mispredict: ex_pc_i=0x40, ex_taken_i=0, ex_pred_taken_i=1 -> decrement_counter_o=1; next cycle flush_o=1, redirect_pc_o=0x44; mispredict_count_o=1; a branch in EX during that cycle is ignored.
REQ-032 SHALL be verified with a target mispredict: taken on both sides, ex_pred_pc_i=0x80, ex_target_i=0x90 -> flush_o=1 with redirect_pc_o=0x90 and the entry updated to 0x90.
REQ-033 SHALL be verified with saturation and reset: force 65536 mispredicts -> mispredict_count_o stays 0xFFFF; assert rst_i during flush_o=1 -> flush_o=0 and both counters=0 without a clock edge.
